// File: rtl/mem_stage.sv
// Memory stage of the five-stage pipeline.
// Holds one instruction from execute, waits for the data-SRAM response when
// the instruction accesses memory, then formats load data and hands the result
// on to writeback. A response that arrives while writeback is stalled is
// parked in a buffer so the SRAM never has to repeat it.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_write_reg,
  output logic [4:0]                 ms_reg_dest,
  output logic                       ms_fwd_ready,
  output logic [31:0]                ms_fwd_data
);

  // IDLE: nothing outstanding; WAIT: response still owed; HOLD: response
  // parked in the buffer until writeback takes the instruction.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] bus_q, bus_d;
  logic [31:0]                rbuf_q, rbuf_d;

  // Fields of the held instruction
  logic [2:0]  load_type;
  logic        mem_access;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] pc;

  assign load_type  = bus_q[73:71];
  assign mem_access = bus_q[70];
  assign gr_we      = bus_q[69];
  assign dest       = bus_q[68:64];
  assign alu_result = bus_q[63:32];
  assign pc         = bus_q[31:0];

  logic        resp_now;
  logic        ms_ready_go;
  logic        accept;
  logic        es_mem_access;
  logic [31:0] load_word;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] final_result;

  // The response that completes the held instruction is only meaningful in WAIT;
  // a data_ok in IDLE or HOLD is a stray and must not move anything.
  assign resp_now      = (state_q == S_WAIT) && data_sram_data_ok;
  assign ms_ready_go   = !mem_access || resp_now || (state_q == S_HOLD);
  assign ms_allowin    = !ms_valid_q || (ms_ready_go && ws_allowin);
  assign accept        = es_to_ms_valid && ms_allowin;
  assign es_mem_access = es_to_ms_bus[70];

  // Pipeline valid and payload registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q <= 1'b0;
      bus_q      <= '0;
      rbuf_q     <= '0;
      state_q    <= S_IDLE;
    end else begin
      ms_valid_q <= ms_valid_d;
      bus_q      <= bus_d;
      rbuf_q     <= rbuf_d;
      state_q    <= state_d;
    end
  end

  // Next-state for valid, payload, response buffer and response FSM
  always_comb begin
    ms_valid_d = ms_valid_q;
    bus_d      = bus_q;
    rbuf_d     = rbuf_q;
    state_d    = state_q;

    if (ms_allowin) begin
      ms_valid_d = es_to_ms_valid;
    end
    if (accept) begin
      bus_d = es_to_ms_bus;
    end
    if (resp_now) begin
      rbuf_d = data_sram_rdata;
    end

    // A newly accepted instruction always starts fresh: a data_ok seen in the
    // same cycle belongs to the departing instruction, never to the new one.
    if (ms_allowin) begin
      state_d = (accept && es_mem_access) ? S_WAIT : S_IDLE;
    end else if (resp_now) begin
      state_d = S_HOLD;
    end
  end

  // Load data alignment and extension
  always_comb begin
    load_word = (state_q == S_HOLD) ? rbuf_q : data_sram_rdata;

    load_byte = load_word[7:0];
    case (alu_result[1:0])
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase

    load_half = alu_result[1] ? load_word[31:16] : load_word[15:0];

    final_result = alu_result;
    case (load_type)
      3'b001:  final_result = load_word;
      3'b010:  final_result = {{24{load_byte[7]}}, load_byte};
      3'b011:  final_result = {24'd0, load_byte};
      3'b100:  final_result = {{16{load_half[15]}}, load_half};
      3'b101:  final_result = {16'd0, load_half};
      default: final_result = alu_result;
    endcase
  end

  assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
  assign ms_to_ws_bus   = {gr_we, dest, final_result, pc};

  assign ms_write_reg = ms_valid_q && gr_we;
  assign ms_reg_dest  = dest;
  assign ms_fwd_ready = ms_valid_q && ms_ready_go;
  assign ms_fwd_data  = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Testbench for mem_stage: a transaction-level reference model of the held
// instruction is compared against the DUT every cycle, under directed
// scenarios followed by randomized traffic.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        es_to_ms_valid;
  logic [73:0] es_to_ms_bus;
  logic        ms_allowin;
  logic        ws_allowin;
  logic        ms_to_ws_valid;
  logic [69:0] ms_to_ws_bus;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ms_write_reg;
  logic [4:0]  ms_reg_dest;
  logic        ms_fwd_ready;
  logic [31:0] ms_fwd_data;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .ws_allowin        (ws_allowin),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ms_write_reg      (ms_write_reg),
    .ms_reg_dest       (ms_reg_dest),
    .ms_fwd_ready      (ms_fwd_ready),
    .ms_fwd_data       (ms_fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit checking = 1'b0;

  // Reference model: the single instruction held by the stage, whether its
  // memory response has been received, and the received word.
  logic        h_valid = 1'b0;
  logic [73:0] h_bus   = '0;
  logic        h_got   = 1'b0;
  logic [31:0] h_data  = '0;

  task automatic chk(input string tag, input logic [73:0] got, input logic [73:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [73:0] mk(input logic [2:0] lt, input logic mem, input logic we,
                                     input logic [4:0] dst, input logic [31:0] alu,
                                     input logic [31:0] pc);
    return {lt, mem, we, dst, alu, pc};
  endfunction

  // Result from load type, address and memory word, using shifts, masks and
  // offset-subtract sign extension.
  function automatic logic [31:0] load_result(input logic [2:0] lt, input logic [31:0] a,
                                              input logic [31:0] d);
    logic [31:0] b, h;
    int sb, sh;
    sb = int'(a[1:0]) * 8;
    sh = a[1] ? 16 : 0;
    b  = (d >> sb) & 32'hFF;
    h  = (d >> sh) & 32'hFFFF;
    case (lt)
      3'd1:    return d;
      3'd2:    return (b ^ 32'h80) - 32'h80;
      3'd3:    return b;
      3'd4:    return (h ^ 32'h8000) - 32'h8000;
      3'd5:    return h;
      default: return a;
    endcase
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, advance model.
  task automatic step(input logic ev, input logic [73:0] eb, input logic ws,
                      input logic dok, input logic [31:0] rd, input logic rst);
    logic        mem, ready, exp_allow, exp_ov;
    logic [31:0] dsel, fin;
    @(negedge clk);
    reset             = rst;
    es_to_ms_valid    = ev;
    es_to_ms_bus      = eb;
    ws_allowin        = ws;
    data_sram_data_ok = dok;
    data_sram_rdata   = rd;
    #1;
    mem       = h_bus[70];
    dsel      = h_got ? h_data : rd;
    ready     = !mem || h_got || dok;
    exp_allow = !h_valid || (ready && ws);
    exp_ov    = h_valid && ready;
    fin       = load_result(h_bus[73:71], h_bus[63:32], dsel);
    if (checking) begin
      chk("allowin",   74'(ms_allowin),     74'(exp_allow));
      chk("out_valid", 74'(ms_to_ws_valid), 74'(exp_ov));
      chk("write_reg", 74'(ms_write_reg),   74'(h_valid && h_bus[69]));
      chk("reg_dest",  74'(ms_reg_dest),    74'(h_bus[68:64]));
      chk("fwd_ready", 74'(ms_fwd_ready),   74'(exp_ov));
      if (exp_ov) begin
        chk("out_bus",  74'(ms_to_ws_bus), 74'({h_bus[69], h_bus[68:64], fin, h_bus[31:0]}));
        chk("fwd_data", 74'(ms_fwd_data),  74'(fin));
      end
    end
    if (rst) begin
      h_valid = 1'b0;
      h_bus   = '0;
      h_got   = 1'b0;
      h_data  = '0;
    end else if (exp_allow) begin
      h_valid = ev;
      h_got   = 1'b0;
      if (ev) h_bus = eb;
    end else if (mem && dok && !h_got) begin
      h_got  = 1'b1;
      h_data = rd;
    end
  endtask

  function automatic logic [73:0] rand_instr();
    logic [2:0] lt;
    int kind;
    kind = $urandom_range(0, 3);
    if (kind == 0) begin
      lt = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(6, 7));
      return mk(lt, 1'b0, 1'($urandom), 5'($urandom), $urandom, $urandom);
    end else if (kind == 1) begin
      return mk(3'd0, 1'b1, 1'b0, 5'($urandom), $urandom, $urandom);
    end
    lt = 3'($urandom_range(1, 5));
    return mk(lt, 1'b1, 1'b1, 5'($urandom), $urandom, $urandom);
  endfunction

  logic [73:0] nil;

  initial begin
    nil = '0;
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
    ws_allowin = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;

    // Reset state
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b1);
    checking = 1'b1;
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, nil, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("rst_allowin", 74'(ms_allowin), 74'(1));
    chk("rst_valid",   74'(ms_to_ws_valid), 74'(0));
    chk("rst_dest",    74'(ms_reg_dest), 74'(0));
    $display("txn reset_state");

    // LB, data_ok two cycles after accept, writeback ready
    step(1'b1, mk(3'd2, 1'b1, 1'b1, 5'd3, 32'h1003, 32'h100), 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("lb_wait_valid", 74'(ms_to_ws_valid), 74'(0));
    step(1'b0, nil, 1'b1, 1'b1, 32'h80FF_1234, 1'b0);
    chk("lb_valid", 74'(ms_to_ws_valid), 74'(1));
    chk("lb_final", 74'(ms_to_ws_bus[63:32]), 74'(32'hFFFF_FF80));
    $display("txn lb result=%h", ms_to_ws_bus[63:32]);

    // LHU with writeback stalled for three cycles after the response
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, mk(3'd5, 1'b1, 1'b1, 5'd7, 32'h2002, 32'h104), 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd9, 32'h55, 32'h108), 1'b0, 1'b1, 32'hBEEF_0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'd9, 32'h55, 32'h108), 1'b0, 1'b1, 32'h1111_2222, 1'b0);
      chk("lhu_hold_allowin", 74'(ms_allowin), 74'(0));
      chk("lhu_hold_final",   74'(ms_to_ws_bus[63:32]), 74'(32'h0000_BEEF));
    end
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("lhu_final", 74'(ms_to_ws_bus[63:32]), 74'(32'h0000_BEEF));
    $display("txn lhu result=%h", ms_to_ws_bus[63:32]);

    // Back-to-back ALU ops with stray data_ok pulses
    for (int i = 0; i < 6; i++) begin
      step(1'b1, mk(3'd0, 1'b0, 1'b1, 5'(i + 1), 32'(i * 16 + 3), 32'(i * 4)),
           1'b1, 1'($urandom), $urandom, 1'b0);
      $display("txn alu %0d", i);
    end
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("alu_last", 74'(ms_to_ws_bus[63:32]), 74'(32'd83));

    // Store then LW; first data_ok finishes store, second the load
    step(1'b1, mk(3'd0, 1'b1, 1'b0, 5'd4, 32'h300, 32'h200), 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd5, 32'h302, 32'h204), 1'b1, 1'b1, 32'hAAAA_AAAA, 1'b0);
    chk("st_valid", 74'(ms_to_ws_valid), 74'(1));
    chk("st_gr_we", 74'(ms_to_ws_bus[69]), 74'(0));
    // Load dest=5 waiting for its response
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("wait_write_reg", 74'(ms_write_reg), 74'(1));
    chk("wait_dest",      74'(ms_reg_dest), 74'(5));
    chk("wait_fwd_ready", 74'(ms_fwd_ready), 74'(0));
    step(1'b0, nil, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
    chk("lw_fwd_ready", 74'(ms_fwd_ready), 74'(1));
    chk("lw_final", 74'(ms_to_ws_bus[63:32]), 74'(32'h1234_5678));
    $display("txn store_lw result=%h", ms_to_ws_bus[63:32]);

    // Reset in WAIT, then a late data_ok
    step(1'b1, mk(3'd1, 1'b1, 1'b1, 5'd6, 32'h400, 32'h300), 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b0, nil, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b0, nil, 1'b1, 1'b1, 32'h9999_9999, 1'b0);
    chk("rstw_valid",   74'(ms_to_ws_valid), 74'(0));
    chk("rstw_allowin", 74'(ms_allowin), 74'(1));
    $display("txn reset_in_wait");

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 9) < 6), rand_instr(), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 9) < 3), $urandom, 1'($urandom_range(0, 199) == 0));
      if (ms_to_ws_valid && ws_allowin)
        $display("txn rand pc=%h result=%h", ms_to_ws_bus[31:0], ms_to_ws_bus[63:32]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ES_TO_MS_BUS_WD, 74, input bus width: [73:71] load_type, [70] mem_access, [69] gr_we, [68:64] dest, [63:32] alu_result, [31:0] pc.
REQ-002 Parameter MS_TO_WS_BUS_WD, 70, output bus width: [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 es_to_ms_valid  input  1  upstream (execute) holds a valid instruction.
REQ-006 es_to_ms_bus  input  ES_TO_MS_BUS_WD  upstream payload.
REQ-007 ms_allowin  output  1  stage accepts a new instruction this cycle.
REQ-008 ws_allowin  input  1  writeback stage accepts this cycle.
REQ-009 ms_to_ws_valid  output  1  payload on ms_to_ws_bus is valid.
REQ-010 ms_to_ws_bus  output  MS_TO_WS_BUS_WD  downstream payload.
REQ-011 data_sram_data_ok  input  1  one-cycle pulse: response for the oldest outstanding data request.
REQ-012 data_sram_rdata  input  32  read data, valid only while data_sram_data_ok=1.
REQ-013 ms_write_reg  output  1  stage holds a valid register-writing instruction (hazard detect).
REQ-014 ms_reg_dest  output  5  destination register of held instruction.
REQ-015 ms_fwd_ready  output  1  ms_fwd_data is final this cycle.
REQ-016 ms_fwd_data  output  32  forwarding value (= final_result).

Function
REQ-017 ms_valid register; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); on ms_allowin, ms_valid <= es_to_ms_valid.
REQ-018 Payload register loads es_to_ms_bus only when es_to_ms_valid && ms_allowin; otherwise holds.
REQ-019 Response FSM states: IDLE (nothing pending), WAIT (mem access held, no response yet), HOLD (response captured, not yet passed downstream).
REQ-020 Instruction accepted with mem_access=1 -> WAIT; accepted with mem_access=0, or no instruction accepted while leaving -> IDLE.
REQ-021 WAIT with data_sram_data_ok=1: capture rdata into 32-bit buffer; if ws_allowin same cycle, leave per REQ-020, else -> HOLD.
REQ-022 HOLD: leave per REQ-020 when ws_allowin=1; data_sram_data_ok in HOLD or IDLE ignored.
REQ-023 data_sram_data_ok in the same cycle an instruction is accepted belongs to the previous instruction only if it was in WAIT; it never completes the newly accepted one.
REQ-024 ms_ready_go = !mem_access || (state==WAIT && data_sram_data_ok) || state==HOLD.
REQ-025 ms_to_ws_valid = ms_valid && ms_ready_go; stall without bubble when ws_allowin=0.
REQ-026 Load data source: data_sram_rdata in WAIT-completion cycle, buffer in HOLD.
REQ-027 load_type: 001 LW full word; 010 LB sign-extend byte alu_result[1:0]; 011 LBU zero-extend same byte; 100 LH sign-extend halfword alu_result[1] (0=[15:0], 1=[31:16]); 101 LHU zero-extend same; 000/110/111 final_result = alu_result.
REQ-028 Byte lane n = rdata[8n+7:8n]; alu_result[0] ignored for LH/LHU, alu_result[1:0] ignored for LW; no misalignment exception.
REQ-029 Stores: mem_access=1, gr_we=0, load_type=000; still wait for data_ok.
REQ-030 ms_write_reg = ms_valid && gr_we; ms_reg_dest = dest; ms_fwd_ready = ms_valid && ms_ready_go.
REQ-031 Exactly one response consumed per mem-access instruction; latency from acceptance = data_ok arrival, min 1 cycle later.

Reset
REQ-032 reset=1: ms_valid<=0, state<=IDLE, payload register and buffer <=0; outputs next cycle: ms_allowin=1, ms_to_ws_valid=0, ms_write_reg=0, ms_reg_dest=0, ms_fwd_ready=0.
REQ-033 Reset mid-WAIT/HOLD discards instruction and buffered data; data_ok arriving after reset in IDLE ignored.

Verification
REQ-034 LB: alu_result=0x1003, rdata=0x80FF_1234, data_ok 2 cycles after accept, ws_allowin=1 -> ms_to_ws_valid same cycle as data_ok, final_result=0xFFFF_FF80.
REQ-035 LHU alu_result=0x2002, rdata=0xBEEF_0001, ws_allowin=0 three cycles after data_ok -> state HOLD, ms_allowin=0, output held, final_result=0x0000_BEEF when ws_allowin rises.
REQ-036 Back-to-back ALU ops (mem_access=0), ws_allowin=1 -> one instruction out per cycle, final_result=alu_result, ignore stray data_ok.
REQ-037 Store then LW: store completes on first data_ok, LW takes second data_ok rdata=0x1234_5678 -> final_result=0x1234_5678, gr_we for store=0.
REQ-038 reset asserted in WAIT, data_ok next cycle -> ms_to_ws_valid stays 0, ms_allowin=1, state IDLE.
REQ-039 Load dest=5 in WAIT -> ms_write_reg=1, ms_reg_dest=5, ms_fwd_ready=0 until data_ok cycle.
